// File: rtl/hazard_probe_sched.sv
// hazard_probe_sched: time-shares one map ROM read port between two
// characters. Each granted request issues three probe reads (feet centre,
// lifted left and lifted right). It then reports whether any returned colour
// is lethal for that character.
// Optional feature: define HAZARD_EARLY_EXIT_EN to jump straight to REPORT
// on a hit seen in PROBE1 or PROBE2.
module hazard_probe_sched #(
    parameter logic [23:0] HAZ0_A   = 24'hAC0404,
    parameter logic [23:0] HAZ0_B   = 24'h69A42A,
    parameter logic [23:0] HAZ1_A   = 24'h2A5CAC,
    parameter logic [23:0] HAZ1_B   = 24'h69A42A,
    parameter int          PROBE_DX = 8,
    parameter int          PROBE_DY = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [1:0]  req,
    input  logic [9:0]  req_x0,
    input  logic [9:0]  req_x1,
    input  logic [9:0]  req_y0,
    input  logic [9:0]  req_y1,
    input  logic [6:0]  req_h0,
    input  logic [6:0]  req_h1,
    output logic [1:0]  req_ack,
    output logic [16:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic [1:0]  done,
    output logic [1:0]  dead,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PROBE0 = 3'd1,
        PROBE1 = 3'd2,
        PROBE2 = 3'd3,
        DRAIN  = 3'd4,
        REPORT = 3'd5
    } state_t;

    localparam logic [16:0] DX_W  = 17'(PROBE_DX);
    localparam logic [16:0] DY_W  = 17'(PROBE_DY);
    localparam logic [16:0] X_MAX = 17'd639;
    localparam logic [16:0] Y_MAX = 17'd479;

    // Feet row: centre plus half height, pinned to the last visible line.
    function automatic logic [16:0] calc_yb(input logic [9:0] y, input logic [6:0] h);
        logic [16:0] s;
        s = {7'd0, y} + {11'd0, h[6:1]};
        if (s > Y_MAX) s = Y_MAX;
        return s;
    endfunction

    function automatic logic [16:0] x_left(input logic [16:0] xv);
        return (xv < DX_W) ? 17'd0 : (xv - DX_W);
    endfunction

    function automatic logic [16:0] x_right(input logic [16:0] xv);
        logic [16:0] s;
        s = xv + DX_W;
        return (s > X_MAX) ? X_MAX : s;
    endfunction

    function automatic logic [16:0] y_up(input logic [16:0] yv);
        return (yv < DY_W) ? 17'd0 : (yv - DY_W);
    endfunction

    // The map is stored at quarter resolution, 160 cells per row.
    function automatic logic [16:0] cell_addr(input logic [16:0] xv, input logic [16:0] yv);
        return (xv >> 2) + ((yv >> 2) * 17'd160);
    endfunction

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic        hit_q;
    logic        busy_q;
    logic [1:0]  req_ack_q;
    logic [1:0]  done_q;
    logic [1:0]  dead_q;
    logic [16:0] rom_addr_q;
    logic [16:0] x_q;
    logic [16:0] yb_q;

    logic        gnt_w;
    logic [9:0]  sel_x;
    logic [9:0]  sel_y;
    logic [6:0]  sel_h;
    logic [16:0] yb_w;
    logic [16:0] a1_w;
    logic [16:0] a2_w;
    logic [16:0] a3_w;
    logic        match_w;

    // Round-robin: on a tie the requester not granted last wins.
    assign gnt_w = (req[0] & req[1]) ? ~last_q : req[1];
    assign sel_x = gnt_w ? req_x1 : req_x0;
    assign sel_y = gnt_w ? req_y1 : req_y0;
    assign sel_h = gnt_w ? req_h1 : req_h0;
    assign yb_w  = calc_yb(sel_y, sel_h);
    assign a1_w  = cell_addr({7'd0, sel_x}, yb_w);
    assign a2_w  = cell_addr(x_left(x_q), y_up(yb_q));
    assign a3_w  = cell_addr(x_right(x_q), y_up(yb_q));

    assign match_w = owner_q ? ((rom_data == HAZ1_A) || (rom_data == HAZ1_B))
                             : ((rom_data == HAZ0_A) || (rom_data == HAZ0_B));

    assign req_ack  = req_ack_q;
    assign rom_addr = rom_addr_q;
    assign done     = done_q;
    assign dead     = dead_q;
    assign busy     = busy_q;

    // Capture the granted character position; A1 is issued straight from the inputs.
    always_ff @(posedge Clk) begin
        if (state_q == IDLE && (|req)) begin
            x_q  <= {7'd0, sel_x};
            yb_q <= yb_w;
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
            req_ack_q  <= 2'b00;
            done_q     <= 2'b00;
            dead_q     <= 2'b00;
            rom_addr_q <= 17'd0;
        end else begin
            req_ack_q <= 2'b00;
            done_q    <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q    <= PROBE0;
                        owner_q    <= gnt_w;
                        last_q     <= gnt_w;
                        req_ack_q  <= gnt_w ? 2'b10 : 2'b01;
                        hit_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        rom_addr_q <= a1_w;
                    end
                end
                PROBE0: begin
                    rom_addr_q <= a2_w;
                    state_q    <= PROBE1;
                end
                PROBE1: begin
                    hit_q <= hit_q | match_w;
`ifdef HAZARD_EARLY_EXIT_EN
                    if (match_w) begin
                        dead_q[owner_q] <= 1'b1;
                        done_q[owner_q] <= 1'b1;
                        rom_addr_q      <= 17'd0;
                        state_q         <= REPORT;
                    end else begin
                        rom_addr_q <= a3_w;
                        state_q    <= PROBE2;
                    end
`else
                    rom_addr_q <= a3_w;
                    state_q    <= PROBE2;
`endif
                end
                PROBE2: begin
                    hit_q <= hit_q | match_w;
`ifdef HAZARD_EARLY_EXIT_EN
                    if (match_w) begin
                        dead_q[owner_q] <= 1'b1;
                        done_q[owner_q] <= 1'b1;
                        rom_addr_q      <= 17'd0;
                        state_q         <= REPORT;
                    end else begin
                        state_q <= DRAIN;
                    end
`else
                    state_q <= DRAIN;
`endif
                end
                DRAIN: begin
                    // Last read returns now; verdict and done appear together in REPORT.
                    hit_q           <= hit_q | match_w;
                    dead_q[owner_q] <= hit_q | match_w;
                    done_q[owner_q] <= 1'b1;
                    rom_addr_q      <= 17'd0;
                    state_q         <= REPORT;
                end
                REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q     <= 1'b0;
                    rom_addr_q <= 17'd0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_probe_sched.sv
// Directed bench for hazard_probe_sched with a one-cycle-latency ROM model.
module tb_hazard_probe_sched;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [9:0]  req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
    logic [6:0]  req_h0 = '0, req_h1 = '0;
    logic [1:0]  req_ack;
    logic [16:0] rom_addr;
    logic [23:0] rom_data;
    logic [1:0]  done;
    logic [1:0]  dead;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // ROM model controls
    logic        lethal_en   = 1'b0;
    logic [16:0] lethal_addr = '0;
    logic [23:0] lethal_col  = '0;
    logic        all_col_en  = 1'b0;
    logic [23:0] all_col     = '0;
    logic [16:0] rom_q       = '0;

    hazard_probe_sched dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .req_h0(req_h0), .req_h1(req_h1),
        .req_ack(req_ack), .rom_addr(rom_addr), .rom_data(rom_data),
        .done(done), .dead(dead), .busy(busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_q <= rom_addr;

    always_comb begin
        rom_data = 24'h123456;
        if (all_col_en) rom_data = all_col;
        if (lethal_en && rom_q == lethal_addr) rom_data = lethal_col;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int w, input int x, input int y, input int h);
        if (w == 0) begin
            req_x0 = 10'(x); req_y0 = 10'(y); req_h0 = 7'(h);
        end else begin
            req_x1 = 10'(x); req_y1 = 10'(y); req_h1 = 7'(h);
        end
        req = 2'(1 << w);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        req = 2'b00;
        tick();
        tick();
        checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", req_ack); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
        checks++; if (dead !== 2'b00) begin errors++; $display("FAIL reset_dead got %b want 00", dead); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rom_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_address();
        int tw [5] = '{0, 0, 1, 1, 0};
        int tx [5] = '{100, 4, 636, 100, 1023};
        int ty [5] = '{200, 470, 0, 200, 479};
        int th [5] = '{32, 127, 0, 32, 127};
        int a1 [5] = '{8665, 19041, 159, 8665, 19295};
        int a2 [5] = '{8503, 18880, 157, 8503, 19133};
        int a3 [5] = '{8507, 18883, 159, 8507, 19039};
        for (int i = 0; i < 5; i++) begin
            set_req(tw[i], tx[i], ty[i], th[i]);
            tick();
            req = 2'b00;
            checks++; if (req_ack !== 2'(1 << tw[i])) begin errors++; $display("FAIL addr_ack[%0d] got %b want %b", i, req_ack, 2'(1 << tw[i])); end
            checks++; if (rom_addr !== 17'(a1[i])) begin errors++; $display("FAIL addr_a1[%0d] got %0d want %0d", i, rom_addr, a1[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addr_busy[%0d] got %b want 1", i, busy); end
            tick();
            checks++; if (rom_addr !== 17'(a2[i])) begin errors++; $display("FAIL addr_a2[%0d] got %0d want %0d", i, rom_addr, a2[i]); end
            tick();
            checks++; if (rom_addr !== 17'(a3[i])) begin errors++; $display("FAIL addr_a3[%0d] got %0d want %0d", i, rom_addr, a3[i]); end
            tick();
            checks++; if (rom_addr !== 17'(a3[i])) begin errors++; $display("FAIL addr_drain[%0d] got %0d want %0d", i, rom_addr, a3[i]); end
            checks++; if (done !== 2'b00) begin errors++; $display("FAIL addr_early_done[%0d] got %b want 00", i, done); end
            tick();
            checks++; if (done !== 2'(1 << tw[i])) begin errors++; $display("FAIL addr_done[%0d] got %b want %b", i, done, 2'(1 << tw[i])); end
            checks++; if (dead !== 2'b00) begin errors++; $display("FAIL addr_dead[%0d] got %b want 00", i, dead); end
            checks++; if (rom_addr !== 17'd0) begin errors++; $display("FAIL addr_report[%0d] got %0d want 0", i, rom_addr); end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addr_idle[%0d] got %b want 0", i, busy); end
            checks++; if (done !== 2'b00) begin errors++; $display("FAIL addr_pulse[%0d] got %b want 00", i, done); end
        end
    endtask

    task automatic test_lethal();
        int done_tick;
`ifdef HAZARD_EARLY_EXIT_EN
        done_tick = 4;
`else
        done_tick = 5;
`endif
        lethal_en   = 1'b1;
        lethal_addr = 17'd8503;
        lethal_col  = 24'hAC0404;
        set_req(0, 100, 200, 32);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) req = 2'b00;
            checks++;
            if (done !== ((k == done_tick) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL lethal_done t%0d got %b want %b", k, done, (k == done_tick) ? 2'b01 : 2'b00);
            end
        end
        checks++; if (dead !== 2'b01) begin errors++; $display("FAIL lethal_dead got %b want 01", dead); end
        // Same colour is harmless for requester 1; dead[0] must be left alone.
        set_req(1, 100, 200, 32);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) req = 2'b00;
            if (k == 5) begin
                checks++; if (done !== 2'b10) begin errors++; $display("FAIL lethal_r1_done got %b want 10", done); end
            end
        end
        checks++; if (dead !== 2'b01) begin errors++; $display("FAIL lethal_hold got %b want 01", dead); end
        lethal_en = 1'b0;
    endtask

    task automatic test_reset_mid_probe();
        set_req(0, 100, 200, 32);
        tick();
        req = 2'b00;
        tick();
        checks++; if (rom_addr !== 17'd8503) begin errors++; $display("FAIL mid_probe1 got %0d want 8503", rom_addr); end
        Reset_n = 1'b0;
        #1;
        checks++; if (rom_addr !== 17'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (dead !== 2'b00) begin errors++; $display("FAIL mid_dead got %b want 00", dead); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (done !== 2'b00) begin errors++; $display("FAIL mid_done t%0d got %b want 00", k, done); end
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        set_req(0, 4, 470, 127);
        tick();
        req = 2'b00;
        checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL restart_ack got %b want 01", req_ack); end
        checks++; if (rom_addr !== 17'd19041) begin errors++; $display("FAIL restart_a1 got %0d want 19041", rom_addr); end
        for (int k = 2; k <= 6; k++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle got %b want 0", busy); end
    endtask

    task automatic test_arbitration();
        logic [1:0] e_ack;
        logic [1:0] e_done;
        logic [1:0] e_dead;
        Reset_n = 1'b0;
        #3;
        @(negedge Clk);
        Reset_n = 1'b1;
        all_col_en = 1'b1;
        all_col    = 24'h2A5CAC;
        req_x0 = 10'd100; req_y0 = 10'd200; req_h0 = 7'd32;
        req_x1 = 10'd300; req_y1 = 10'd100; req_h1 = 7'd20;
        req = 2'b11;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 13) req = 2'b00;
            e_ack  = (k == 1 || k == 13) ? 2'b01 : ((k == 7) ? 2'b10 : 2'b00);
            e_done = (k == 5 || k == 17) ? 2'b01 : ((k == 11) ? 2'b10 : 2'b00);
            e_dead = (k >= 11) ? 2'b10 : 2'b00;
            checks++; if (req_ack !== e_ack) begin errors++; $display("FAIL arb_ack t%0d got %b want %b", k, req_ack, e_ack); end
            checks++; if (done !== e_done) begin errors++; $display("FAIL arb_done t%0d got %b want %b", k, done, e_done); end
            checks++; if (dead !== e_dead) begin errors++; $display("FAIL arb_dead t%0d got %b want %b", k, dead, e_dead); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle got %b want 0", busy); end
        all_col_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_address();
        test_lethal();
        test_reset_mid_probe();
        test_arbitration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
